// File: rtl/alu_rs_pkg.sv
// rtl/alu_rs_pkg.sv - shared widths, opcode encodings and entry types for the ALU reservation station
package alu_rs_pkg;

    localparam int OP_LEN     = 6;
    localparam int DATA_LEN   = 32;
    localparam int ROB_LEN    = 4;
    localparam int RS_SIZE    = 8;
    localparam int RS_IDX_LEN = 3;

    localparam logic [OP_LEN-1:0] OP_ADD  = 6'd1;
    localparam logic [OP_LEN-1:0] OP_SUB  = 6'd2;
    localparam logic [OP_LEN-1:0] OP_AND  = 6'd3;
    localparam logic [OP_LEN-1:0] OP_OR   = 6'd4;
    localparam logic [OP_LEN-1:0] OP_XOR  = 6'd5;
    localparam logic [OP_LEN-1:0] OP_SLL  = 6'd6;
    localparam logic [OP_LEN-1:0] OP_SRL  = 6'd7;
    localparam logic [OP_LEN-1:0] OP_SRA  = 6'd8;
    localparam logic [OP_LEN-1:0] OP_SLT  = 6'd9;
    localparam logic [OP_LEN-1:0] OP_SLTU = 6'd10;
    localparam logic [OP_LEN-1:0] OP_ADDI = 6'd11;
    localparam logic [OP_LEN-1:0] OP_LUI  = 6'd12;

    // One source operand: a value once rdy is set, otherwise the producer ROB tag.
    typedef struct packed {
        logic                rdy;
        logic [DATA_LEN-1:0] val;
        logic [ROB_LEN-1:0]  tag;
    } operand_t;

    typedef struct packed {
        logic [OP_LEN-1:0]   op;
        logic [DATA_LEN-1:0] imm;
        logic [DATA_LEN-1:0] pc;
        logic [ROB_LEN-1:0]  robpos;
        operand_t            rs1;
        operand_t            rs2;
    } rs_entry_t;

    // Snoop both result buses for a waiting operand; shared by wakeup and dispatch bypass.
    function automatic operand_t resolve_operand(
        input operand_t            opnd,
        input logic                alu_flag,
        input logic [DATA_LEN-1:0] alu_val,
        input logic [ROB_LEN-1:0]  alu_robpos,
        input logic                lsb_flag,
        input logic [DATA_LEN-1:0] lsb_val,
        input logic [ROB_LEN-1:0]  lsb_robpos
    );
        operand_t res;
        res = opnd;
        if (!opnd.rdy) begin
            if (alu_flag && (opnd.tag == alu_robpos)) begin
                res.rdy = 1'b1;
                res.val = alu_val;
            end else if (lsb_flag && (opnd.tag == lsb_robpos)) begin
                res.rdy = 1'b1;
                res.val = lsb_val;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/alu_rs_if.sv
// rtl/alu_rs_if.sv - dispatch, broadcast and issue bundle of the ALU reservation station
interface alu_rs_if;
    import alu_rs_pkg::*;

    logic                  i_ready;
    logic                  i_clear;

    logic                  i_disp_valid;
    logic [OP_LEN-1:0]     i_disp_op;
    logic [DATA_LEN-1:0]   i_disp_imm;
    logic [DATA_LEN-1:0]   i_disp_pc;
    logic [ROB_LEN-1:0]    i_disp_robpos;
    logic                  i_disp_rs1_rdy;
    logic [DATA_LEN-1:0]   i_disp_rs1_val;
    logic [ROB_LEN-1:0]    i_disp_rs1_tag;
    logic                  i_disp_rs2_rdy;
    logic [DATA_LEN-1:0]   i_disp_rs2_val;
    logic [ROB_LEN-1:0]    i_disp_rs2_tag;

    logic                  i_alu_flag;
    logic [DATA_LEN-1:0]   i_alu_val;
    logic [ROB_LEN-1:0]    i_alu_robpos;
    logic                  i_lsb_flag;
    logic [DATA_LEN-1:0]   i_lsb_val;
    logic [ROB_LEN-1:0]    i_lsb_robpos;

    logic                  o_rs_full;
    logic                  o_work;
    logic [OP_LEN-1:0]     o_op;
    logic [DATA_LEN-1:0]   o_imm;
    logic [DATA_LEN-1:0]   o_pc;
    logic [ROB_LEN-1:0]    o_robpos;
    logic [DATA_LEN-1:0]   o_rs1;
    logic [DATA_LEN-1:0]   o_rs2;

    modport master (
        output i_ready, i_clear,
        output i_disp_valid, i_disp_op, i_disp_imm, i_disp_pc, i_disp_robpos,
        output i_disp_rs1_rdy, i_disp_rs1_val, i_disp_rs1_tag,
        output i_disp_rs2_rdy, i_disp_rs2_val, i_disp_rs2_tag,
        output i_alu_flag, i_alu_val, i_alu_robpos,
        output i_lsb_flag, i_lsb_val, i_lsb_robpos,
        input  o_rs_full, o_work, o_op, o_imm, o_pc, o_robpos, o_rs1, o_rs2
    );

    modport slave (
        input  i_ready, i_clear,
        input  i_disp_valid, i_disp_op, i_disp_imm, i_disp_pc, i_disp_robpos,
        input  i_disp_rs1_rdy, i_disp_rs1_val, i_disp_rs1_tag,
        input  i_disp_rs2_rdy, i_disp_rs2_val, i_disp_rs2_tag,
        input  i_alu_flag, i_alu_val, i_alu_robpos,
        input  i_lsb_flag, i_lsb_val, i_lsb_robpos,
        output o_rs_full, o_work, o_op, o_imm, o_pc, o_robpos, o_rs1, o_rs2
    );

endinterface

// File: rtl/alu_rs_pick.sv
// rtl/alu_rs_pick.sv - lowest-index set-bit finder over the station entries
module alu_rs_pick
    import alu_rs_pkg::*;
(
    input  logic [RS_SIZE-1:0]    i_req,
    output logic [RS_IDX_LEN-1:0] o_idx,
    output logic                  o_found
);

    // Scan from the top down so the lowest requesting index is written last and wins.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx   = RS_IDX_LEN'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// rtl/alu_rs.sv - 8-entry ALU reservation station with result-bus wakeup and in-order-by-slot issue
module alu_rs
    import alu_rs_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    alu_rs_if.slave  rs_bus
);

    logic [RS_SIZE-1:0]    r_busy;
    rs_entry_t             r_entry [RS_SIZE];

    logic                  r_work;
    logic [OP_LEN-1:0]     r_op;
    logic [DATA_LEN-1:0]   r_imm;
    logic [DATA_LEN-1:0]   r_pc;
    logic [ROB_LEN-1:0]    r_robpos;
    logic [DATA_LEN-1:0]   r_rs1;
    logic [DATA_LEN-1:0]   r_rs2;

    logic [RS_SIZE-1:0]    w_free_req;
    logic [RS_SIZE-1:0]    w_issue_req;
    logic [RS_IDX_LEN-1:0] w_free_idx;
    logic [RS_IDX_LEN-1:0] w_issue_idx;
    logic                  w_free_found;
    logic                  w_issue_found;
    rs_entry_t             w_woken [RS_SIZE];
    rs_entry_t             w_disp_entry;

    // Candidates come from registered state only, so a same-edge wakeup cannot issue until the next edge.
    always_comb begin
        w_free_req  = ~r_busy;
        w_issue_req = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            w_issue_req[i] = r_busy[i] & r_entry[i].rs1.rdy & r_entry[i].rs2.rdy;
        end
    end

    alu_rs_pick u_free_pick (
        .i_req   (w_free_req),
        .o_idx   (w_free_idx),
        .o_found (w_free_found)
    );

    alu_rs_pick u_issue_pick (
        .i_req   (w_issue_req),
        .o_idx   (w_issue_idx),
        .o_found (w_issue_found)
    );

    // Next value of every resident entry after snooping this cycle's result broadcasts.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            w_woken[i]     = r_entry[i];
            w_woken[i].rs1 = resolve_operand(r_entry[i].rs1,
                                             rs_bus.i_alu_flag, rs_bus.i_alu_val, rs_bus.i_alu_robpos,
                                             rs_bus.i_lsb_flag, rs_bus.i_lsb_val, rs_bus.i_lsb_robpos);
            w_woken[i].rs2 = resolve_operand(r_entry[i].rs2,
                                             rs_bus.i_alu_flag, rs_bus.i_alu_val, rs_bus.i_alu_robpos,
                                             rs_bus.i_lsb_flag, rs_bus.i_lsb_val, rs_bus.i_lsb_robpos);
        end
    end

    // Incoming instruction with the same-cycle broadcast bypass already folded in.
    always_comb begin
        w_disp_entry.op      = rs_bus.i_disp_op;
        w_disp_entry.imm     = rs_bus.i_disp_imm;
        w_disp_entry.pc      = rs_bus.i_disp_pc;
        w_disp_entry.robpos  = rs_bus.i_disp_robpos;
        w_disp_entry.rs1.rdy = rs_bus.i_disp_rs1_rdy;
        w_disp_entry.rs1.val = rs_bus.i_disp_rs1_val;
        w_disp_entry.rs1.tag = rs_bus.i_disp_rs1_tag;
        w_disp_entry.rs2.rdy = rs_bus.i_disp_rs2_rdy;
        w_disp_entry.rs2.val = rs_bus.i_disp_rs2_val;
        w_disp_entry.rs2.tag = rs_bus.i_disp_rs2_tag;
        w_disp_entry.rs1     = resolve_operand(w_disp_entry.rs1,
                                               rs_bus.i_alu_flag, rs_bus.i_alu_val, rs_bus.i_alu_robpos,
                                               rs_bus.i_lsb_flag, rs_bus.i_lsb_val, rs_bus.i_lsb_robpos);
        w_disp_entry.rs2     = resolve_operand(w_disp_entry.rs2,
                                               rs_bus.i_alu_flag, rs_bus.i_alu_val, rs_bus.i_alu_robpos,
                                               rs_bus.i_lsb_flag, rs_bus.i_lsb_val, rs_bus.i_lsb_robpos);
    end

    // Station state: reset beats flush beats stall; wakeup, issue and dispatch share one edge.
    // The free slot is picked from pre-edge busy bits, so it can never be the slot being issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= '0;
            r_work <= 1'b0;
        end else if (rs_bus.i_clear) begin
            r_busy <= '0;
            r_work <= 1'b0;
        end else if (rs_bus.i_ready) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (r_busy[i]) begin
                    r_entry[i] <= w_woken[i];
                end
            end

            if (w_issue_found) begin
                r_work              <= 1'b1;
                r_op                <= r_entry[w_issue_idx].op;
                r_imm               <= r_entry[w_issue_idx].imm;
                r_pc                <= r_entry[w_issue_idx].pc;
                r_robpos            <= r_entry[w_issue_idx].robpos;
                r_rs1               <= r_entry[w_issue_idx].rs1.val;
                r_rs2               <= r_entry[w_issue_idx].rs2.val;
                r_busy[w_issue_idx] <= 1'b0;
            end else begin
                r_work <= 1'b0;
            end

            if (rs_bus.i_disp_valid && w_free_found) begin
                r_entry[w_free_idx] <= w_disp_entry;
                r_busy[w_free_idx]  <= 1'b1;
            end
        end
    end

    assign rs_bus.o_rs_full = &r_busy;
    assign rs_bus.o_work    = r_work;
    assign rs_bus.o_op      = r_op;
    assign rs_bus.o_imm     = r_imm;
    assign rs_bus.o_pc      = r_pc;
    assign rs_bus.o_robpos  = r_robpos;
    assign rs_bus.o_rs1     = r_rs1;
    assign rs_bus.o_rs2     = r_rs2;

endmodule

// File: tb/tb_alu_rs.sv
// tb/tb_alu_rs.sv - directed self-checking bench for the ALU reservation station
module tb_alu_rs;
    import alu_rs_pkg::*;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    alu_rs_if bus ();

    alu_rs u_dut (
        .clk    (clk),
        .reset  (reset),
        .rs_bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.i_ready        = 1'b1;
        bus.i_clear        = 1'b0;
        bus.i_disp_valid   = 1'b0;
        bus.i_disp_op      = '0;
        bus.i_disp_imm     = '0;
        bus.i_disp_pc      = '0;
        bus.i_disp_robpos  = '0;
        bus.i_disp_rs1_rdy = 1'b0;
        bus.i_disp_rs1_val = '0;
        bus.i_disp_rs1_tag = '0;
        bus.i_disp_rs2_rdy = 1'b0;
        bus.i_disp_rs2_val = '0;
        bus.i_disp_rs2_tag = '0;
        bus.i_alu_flag     = 1'b0;
        bus.i_alu_val      = '0;
        bus.i_alu_robpos   = '0;
        bus.i_lsb_flag     = 1'b0;
        bus.i_lsb_val      = '0;
        bus.i_lsb_robpos   = '0;
    endtask

    task automatic set_disp(input logic [5:0] op, input logic [31:0] imm, input logic [31:0] pc,
                            input logic [3:0] robpos,
                            input logic r1rdy, input logic [31:0] r1val, input logic [3:0] r1tag,
                            input logic r2rdy, input logic [31:0] r2val, input logic [3:0] r2tag);
        bus.i_disp_valid   = 1'b1;
        bus.i_disp_op      = op;
        bus.i_disp_imm     = imm;
        bus.i_disp_pc      = pc;
        bus.i_disp_robpos  = robpos;
        bus.i_disp_rs1_rdy = r1rdy;
        bus.i_disp_rs1_val = r1val;
        bus.i_disp_rs1_tag = r1tag;
        bus.i_disp_rs2_rdy = r2rdy;
        bus.i_disp_rs2_val = r2val;
        bus.i_disp_rs2_tag = r2tag;
    endtask

    task automatic do_reset;
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 1'b1;
        set_disp(OP_ADD, 32'h0, 32'h0, 4'd2, 1'b1, 32'h1, 4'd0, 1'b1, 32'h2, 4'd0);
        step();
        step();
        n_cmp++; if (bus.o_work !== 1'b0) begin n_bad++; $display("FAIL reset_work: got %0h want 0", bus.o_work); end
        n_cmp++; if (bus.o_rs_full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %0h want 0", bus.o_rs_full); end
        reset = 1'b0;
        idle_inputs();
        step();
        n_cmp++; if (bus.o_work !== 1'b0) begin n_bad++; $display("FAIL reset_drop1: got %0h want 0", bus.o_work); end
        step();
        n_cmp++; if (bus.o_work !== 1'b0) begin n_bad++; $display("FAIL reset_drop2: got %0h want 0", bus.o_work); end
    endtask

    task automatic test_ready_dispatch;
        do_reset();
        set_disp(OP_ADD, 32'h0000_0123, 32'h0000_1000, 4'd3, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0);
        step();
        n_cmp++; if (bus.o_work !== 1'b0) begin n_bad++; $display("FAIL add_early: got %0h want 0", bus.o_work); end
        idle_inputs();
        step();
        n_cmp++; if (bus.o_work !== 1'b1) begin n_bad++; $display("FAIL add_work: got %0h want 1", bus.o_work); end
        n_cmp++; if (bus.o_op !== OP_ADD) begin n_bad++; $display("FAIL add_op: got %0h want %0h", bus.o_op, OP_ADD); end
        n_cmp++; if (bus.o_rs1 !== 32'd5) begin n_bad++; $display("FAIL add_rs1: got %0h want 5", bus.o_rs1); end
        n_cmp++; if (bus.o_rs2 !== 32'd7) begin n_bad++; $display("FAIL add_rs2: got %0h want 7", bus.o_rs2); end
        n_cmp++; if (bus.o_robpos !== 4'd3) begin n_bad++; $display("FAIL add_robpos: got %0h want 3", bus.o_robpos); end
        n_cmp++; if (bus.o_imm !== 32'h0000_0123) begin n_bad++; $display("FAIL add_imm: got %0h want 123", bus.o_imm); end
        n_cmp++; if (bus.o_pc !== 32'h0000_1000) begin n_bad++; $display("FAIL add_pc: got %0h want 1000", bus.o_pc); end
        step();
        n_cmp++; if (bus.o_work !== 1'b0) begin n_bad++; $display("FAIL add_done: got %0h want 0", bus.o_work); end
        n_cmp++; if (bus.o_robpos !== 4'd3) begin n_bad++; $display("FAIL add_hold_payload: got %0h want 3", bus.o_robpos); end
    endtask

    task automatic test_wakeup;
        do_reset();
        set_disp(OP_SUB, 32'h0, 32'h0000_2000, 4'd9, 1'b0, 32'h0, 4'd6, 1'b1, 32'h3, 4'd0);
        step();
        idle_inputs();
        for (int e = 1; e <= 3; e++) begin
            if (e == 2) begin
                bus.i_alu_flag   = 1'b1;
                bus.i_alu_robpos = 4'd14;
                bus.i_alu_val    = 32'hDEAD_BEEF;
            end else begin
                bus.i_alu_flag   = 1'b0;
            end
            step();
            n_cmp++; if (bus.o_work !== 1'b0) begin n_bad++; $display("FAIL sub_wait_e%0d: got %0h want 0", e, bus.o_work); end
        end
        bus.i_alu_flag   = 1'b1;
        bus.i_alu_robpos = 4'd6;
        bus.i_alu_val    = 32'h10;
        step();
        n_cmp++; if (bus.o_work !== 1'b0) begin n_bad++; $display("FAIL sub_same_edge: got %0h want 0", bus.o_work); end
        idle_inputs();
        step();
        n_cmp++; if (bus.o_work !== 1'b1) begin n_bad++; $display("FAIL sub_work: got %0h want 1", bus.o_work); end
        n_cmp++; if (bus.o_op !== OP_SUB) begin n_bad++; $display("FAIL sub_op: got %0h want %0h", bus.o_op, OP_SUB); end
        n_cmp++; if (bus.o_rs1 !== 32'h10) begin n_bad++; $display("FAIL sub_rs1: got %0h want 10", bus.o_rs1); end
        n_cmp++; if (bus.o_rs2 !== 32'h3) begin n_bad++; $display("FAIL sub_rs2: got %0h want 3", bus.o_rs2); end
        n_cmp++; if (bus.o_robpos !== 4'd9) begin n_bad++; $display("FAIL sub_robpos: got %0h want 9", bus.o_robpos); end
    endtask

    task automatic test_bypass;
        do_reset();
        set_disp(OP_XOR, 32'h0, 32'h0, 4'd11, 1'b1, 32'h20, 4'd0, 1'b0, 32'h0, 4'd2);
        bus.i_lsb_flag   = 1'b1;
        bus.i_lsb_robpos = 4'd2;
        bus.i_lsb_val    = 32'hFFFF_FFFF;
        step();
        idle_inputs();
        step();
        n_cmp++; if (bus.o_work !== 1'b1) begin n_bad++; $display("FAIL byp_work: got %0h want 1", bus.o_work); end
        n_cmp++; if (bus.o_rs2 !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL byp_rs2: got %0h want ffffffff", bus.o_rs2); end
        n_cmp++; if (bus.o_rs1 !== 32'h20) begin n_bad++; $display("FAIL byp_rs1: got %0h want 20", bus.o_rs1); end
        n_cmp++; if (bus.o_robpos !== 4'd11) begin n_bad++; $display("FAIL byp_robpos: got %0h want b", bus.o_robpos); end
    endtask

    task automatic test_dual_broadcast;
        do_reset();
        set_disp(OP_AND, 32'h0, 32'h0, 4'd4, 1'b0, 32'h0, 4'd4, 1'b1, 32'h1, 4'd0);
        step();
        set_disp(OP_OR, 32'h0, 32'h0, 4'd5, 1'b1, 32'h2, 4'd0, 1'b0, 32'h0, 4'd5);
        step();
        idle_inputs();
        bus.i_alu_flag   = 1'b1;
        bus.i_alu_robpos = 4'd4;
        bus.i_alu_val    = 32'hAAAA_0000;
        bus.i_lsb_flag   = 1'b1;
        bus.i_lsb_robpos = 4'd5;
        bus.i_lsb_val    = 32'h0000_BBBB;
        step();
        n_cmp++; if (bus.o_work !== 1'b0) begin n_bad++; $display("FAIL dual_same_edge: got %0h want 0", bus.o_work); end
        idle_inputs();
        step();
        n_cmp++; if (bus.o_robpos !== 4'd4 || bus.o_work !== 1'b1) begin n_bad++; $display("FAIL dual_first: got work %0h robpos %0h want 1/4", bus.o_work, bus.o_robpos); end
        n_cmp++; if (bus.o_rs1 !== 32'hAAAA_0000) begin n_bad++; $display("FAIL dual_alu_val: got %0h want aaaa0000", bus.o_rs1); end
        step();
        n_cmp++; if (bus.o_robpos !== 4'd5 || bus.o_work !== 1'b1) begin n_bad++; $display("FAIL dual_second: got work %0h robpos %0h want 1/5", bus.o_work, bus.o_robpos); end
        n_cmp++; if (bus.o_rs2 !== 32'h0000_BBBB) begin n_bad++; $display("FAIL dual_lsb_val: got %0h want bbbb", bus.o_rs2); end
    endtask

    task automatic test_full;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_disp(OP_ADD, 32'h0, 32'h0, 4'(i), 1'b0, 32'h0, 4'(i + 8), 1'b1, 32'h2, 4'd0);
            step();
        end
        n_cmp++; if (bus.o_rs_full !== 1'b1) begin n_bad++; $display("FAIL full_set: got %0h want 1", bus.o_rs_full); end
        set_disp(OP_OR, 32'h0, 32'h0, 4'd12, 1'b1, 32'h9, 4'd0, 1'b1, 32'h9, 4'd0);
        step();
        n_cmp++; if (bus.o_rs_full !== 1'b1 || bus.o_work !== 1'b0) begin n_bad++; $display("FAIL full_ninth: got full %0h work %0h want 1/0", bus.o_rs_full, bus.o_work); end
        idle_inputs();
        bus.i_alu_flag   = 1'b1;
        bus.i_alu_robpos = 4'd13;
        bus.i_alu_val    = 32'h55;
        step();
        n_cmp++; if (bus.o_work !== 1'b0) begin n_bad++; $display("FAIL full_wake_edge: got %0h want 0", bus.o_work); end
        idle_inputs();
        set_disp(OP_XOR, 32'h0, 32'h0, 4'd15, 1'b1, 32'h1, 4'd0, 1'b1, 32'h1, 4'd0);
        step();
        n_cmp++; if (bus.o_work !== 1'b1 || bus.o_robpos !== 4'd5) begin n_bad++; $display("FAIL full_issue5: got work %0h robpos %0h want 1/5", bus.o_work, bus.o_robpos); end
        n_cmp++; if (bus.o_rs1 !== 32'h55) begin n_bad++; $display("FAIL full_rs1: got %0h want 55", bus.o_rs1); end
        n_cmp++; if (bus.o_rs_full !== 1'b0) begin n_bad++; $display("FAIL full_freed: got %0h want 0", bus.o_rs_full); end
        idle_inputs();
        step();
        n_cmp++; if (bus.o_work !== 1'b0) begin n_bad++; $display("FAIL full_no_extra1: got work %0h robpos %0h want 0", bus.o_work, bus.o_robpos); end
        step();
        n_cmp++; if (bus.o_work !== 1'b0 || bus.o_rs_full !== 1'b0) begin n_bad++; $display("FAIL full_no_extra2: got work %0h full %0h want 0/0", bus.o_work, bus.o_rs_full); end
    endtask

    task automatic test_order_stall;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_disp(OP_SLT, 32'h0, 32'h0, 4'(i), 1'b0, 32'h0, 4'(i + 8), 1'b1, 32'h0, 4'd0);
            step();
        end
        idle_inputs();
        bus.i_alu_flag   = 1'b1;
        bus.i_alu_robpos = 4'd9;
        bus.i_alu_val    = 32'h91;
        bus.i_lsb_flag   = 1'b1;
        bus.i_lsb_robpos = 4'd12;
        bus.i_lsb_val    = 32'hC4;
        step();
        idle_inputs();
        step();
        n_cmp++; if (bus.o_work !== 1'b1 || bus.o_robpos !== 4'd1) begin n_bad++; $display("FAIL ord_first: got work %0h robpos %0h want 1/1", bus.o_work, bus.o_robpos); end
        n_cmp++; if (bus.o_rs1 !== 32'h91) begin n_bad++; $display("FAIL ord_first_rs1: got %0h want 91", bus.o_rs1); end
        bus.i_ready      = 1'b0;
        bus.i_alu_flag   = 1'b1;
        bus.i_alu_robpos = 4'd8;
        bus.i_alu_val    = 32'h80;
        set_disp(OP_ADD, 32'h0, 32'h0, 4'd14, 1'b1, 32'h3, 4'd0, 1'b1, 32'h3, 4'd0);
        for (int s = 0; s < 2; s++) begin
            step();
            n_cmp++; if (bus.o_work !== 1'b1 || bus.o_robpos !== 4'd1 || bus.o_rs1 !== 32'h91) begin
                n_bad++; $display("FAIL ord_stall%0d: got work %0h robpos %0h rs1 %0h want 1/1/91", s, bus.o_work, bus.o_robpos, bus.o_rs1);
            end
        end
        idle_inputs();
        step();
        n_cmp++; if (bus.o_work !== 1'b1 || bus.o_robpos !== 4'd4) begin n_bad++; $display("FAIL ord_second: got work %0h robpos %0h want 1/4", bus.o_work, bus.o_robpos); end
        n_cmp++; if (bus.o_rs1 !== 32'hC4) begin n_bad++; $display("FAIL ord_second_rs1: got %0h want c4", bus.o_rs1); end
        for (int s = 0; s < 2; s++) begin
            step();
            n_cmp++; if (bus.o_work !== 1'b0) begin n_bad++; $display("FAIL ord_quiet%0d: got work %0h robpos %0h want 0", s, bus.o_work, bus.o_robpos); end
        end
    endtask

    task automatic test_flush(input bit use_reset);
        do_reset();
        set_disp(OP_SLL, 32'h0, 32'h0, 4'd1, 1'b0, 32'h0, 4'd1, 1'b1, 32'h0, 4'd0);
        step();
        set_disp(OP_SRL, 32'h0, 32'h0, 4'd2, 1'b0, 32'h0, 4'd2, 1'b1, 32'h0, 4'd0);
        step();
        set_disp(OP_AND, 32'h0, 32'h0, 4'd7, 1'b1, 32'h6, 4'd0, 1'b1, 32'h6, 4'd0);
        step();
        set_disp(OP_SRA, 32'h0, 32'h0, 4'd3, 1'b0, 32'h0, 4'd3, 1'b1, 32'h0, 4'd0);
        step();
        n_cmp++; if (bus.o_work !== 1'b1 || bus.o_robpos !== 4'd7) begin n_bad++; $display("FAIL flush%0d_pre: got work %0h robpos %0h want 1/7", use_reset, bus.o_work, bus.o_robpos); end
        set_disp(OP_ADD, 32'h0, 32'h0, 4'd9, 1'b1, 32'h1, 4'd0, 1'b1, 32'h1, 4'd0);
        bus.i_ready = 1'b0;
        if (use_reset) reset = 1'b1;
        else bus.i_clear = 1'b1;
        step();
        reset = 1'b0;
        idle_inputs();
        n_cmp++; if (bus.o_work !== 1'b0 || bus.o_rs_full !== 1'b0) begin n_bad++; $display("FAIL flush%0d_now: got work %0h full %0h want 0/0", use_reset, bus.o_work, bus.o_rs_full); end
        bus.i_alu_flag   = 1'b1;
        bus.i_alu_robpos = 4'd1;
        bus.i_alu_val    = 32'h11;
        bus.i_lsb_flag   = 1'b1;
        bus.i_lsb_robpos = 4'd2;
        bus.i_lsb_val    = 32'h22;
        step();
        idle_inputs();
        bus.i_alu_flag   = 1'b1;
        bus.i_alu_robpos = 4'd3;
        bus.i_alu_val    = 32'h33;
        for (int s = 0; s < 4; s++) begin
            step();
            idle_inputs();
            n_cmp++; if (bus.o_work !== 1'b0) begin n_bad++; $display("FAIL flush%0d_stale%0d: got work %0h robpos %0h want 0", use_reset, s, bus.o_work, bus.o_robpos); end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_ready_dispatch();
        test_wakeup();
        test_bypass();
        test_dual_broadcast();
        test_full();
        test_order_stall();
        test_flush(1'b0);
        test_flush(1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_rs.md
ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 clk  in  1  clock; all state updates on the rising edge.
REQ-002 reset  in  1  reset, synchronous, active-high.
REQ-003 ready  in  1  global stall; when 0, all state and outputs hold.
REQ-004 clear  in  1  mispredict flush, synchronous, active-high.
REQ-005 disp_valid  in  1  dispatch request from decoder.
REQ-006 disp_op / disp_imm / disp_pc  in  6/32/32  instruction fields.
REQ-007 disp_robpos  in  4  destination ROB index.
REQ-008 disp_rs1_rdy / disp_rs1_val / disp_rs1_tag  in  1/32/4  operand 1: value if rdy=1, else ROB producer tag.
REQ-009 disp_rs2_rdy / disp_rs2_val / disp_rs2_tag  in  1/32/4  operand 2, same encoding.
REQ-010 alu_flag / alu_val / alu_robpos  in  1/32/4  ALU result broadcast.
REQ-011 lsb_flag / lsb_val / lsb_robpos  in  1/32/4  load-buffer result broadcast.
REQ-012 rs_full  out  1  combinational; 1 when all 8 entries are busy.
REQ-013 work  out  1  registered issue strobe to the ALU.
REQ-014 op / imm / pc / robpos / rs1 / rs2  out  6/32/32/4/32/32  registered issue payload; valid while work=1.

Function
REQ-015 Capacity: 8 entries, each holding busy, op, imm, pc, robpos, and for each operand a rdy bit, a value and a tag.
REQ-016 Dispatch: on an edge with ready=1, clear=0, disp_valid=1 and rs_full=0, the lowest-index non-busy entry captures the dispatch fields and becomes busy.
REQ-017 A dispatch while rs_full=1 is ignored; the decoder must not issue one.
REQ-018 Wakeup: on each ready edge, every busy entry whose operand has rdy=0 and tag equal to a broadcast robpos (with its flag=1) sets rdy=1 and captures that broadcast value.
REQ-019 Dispatch bypass: a dispatched operand with rdy=0 whose tag matches a same-cycle broadcast is stored with rdy=1 and the broadcast value.
REQ-020 Selection: the issue candidate is the lowest-index busy entry with both operands rdy=1 in current state. Same-edge wakeups do not count, so a wakeup at edge N allows issue no earlier than edge N+1.
REQ-021 Issue: on a ready edge with a candidate, set work=1, load the payload from the candidate, and clear its busy bit. With no candidate, set work=0 and leave the payload unchanged.
REQ-022 At most one issue per cycle.
REQ-023 Latency: an entry dispatched fully ready at edge N sees work=1 with its payload after edge N+1 at the earliest.
REQ-024 Simultaneous dispatch and issue: the entry freed by an issue cannot be reallocated on the same edge. rs_full uses busy bits before the edge.
REQ-025 Simultaneous ALU and LSB broadcasts with different tags are both applied. Equal tags cannot occur, and behaviour for them is unspecified.
REQ-026 Width rules: tags compare on all 4 bits. Values are stored unmodified, with no sign handling in this block.
REQ-027 clear=1 (with ready ignored): all busy bits go to 0, work goes to 0, and any same-edge dispatch is dropped.

Reset
REQ-028 reset=1 sets all busy bits to 0 and work to 0. Payload registers and entry fields are don't-care.
REQ-029 reset takes priority over clear, ready and disp_valid. Reset asserted mid-operation discards all entries.
REQ-030 After reset, rs_full=0.

Structure
REQ-031 Shared constants belong in def.v: OP_LEN, DATA_LEN, ROB_LEN, RS_SIZE=8, RS_IDX_LEN=3, and the opcode encodings.
REQ-032 Lowest-index selection is one sub-module, rs_pick: an 8-bit request vector in; an index plus a found flag out; combinational.
REQ-033 rs_pick is instantiated twice, once for the free-slot search and once for the issue candidate.

Verification
REQ-034 Dispatch ADD with both operands ready (values 5, 7, robpos 3) at edge 0 -> edge 1: work=1, op=ADD, rs1=5, rs2=7, robpos=3; edge 2: work=0.
REQ-035 Dispatch SUB with rs1 tag 6 not ready; at edge 4 alu_flag=1, alu_robpos=6, alu_val=0x10 -> work=1 after edge 5 with rs1=0x10, and not before.
REQ-036 Dispatch with rs2 tag 2 while the same cycle has lsb_flag=1, lsb_robpos=2, lsb_val=0xFFFFFFFF -> issue on the next edge with rs2=0xFFFFFFFF.
REQ-037 Fill 8 non-ready entries -> rs_full=1 and a 9th dispatch is ignored. Wake entry 5 -> it issues, and a dispatch on that same issue edge is still ignored.
REQ-038 Two ready entries at indices 1 and 4 -> index 1 issues first, index 4 on the next edge. Assert ready=0 between them -> work and payload hold, with no extra issue.
REQ-039 Load 3 entries, then pulse clear (and, separately, reset) -> rs_full=0, work=0 next cycle, and no later issue from the old entries.
